// File: rtl/icmp_frame_assembler_pkg.sv
// Shared definitions for the ICMP frame assembler: message geometry and FSM encoding.
package icmp_pkg;

    localparam int ICMP_WORDS    = 6;
    localparam int ICMP_CSUM_LSB = 0;
    localparam int ICMP_CSUM_MSB = 15;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_CSUM = 2'd2,
        ST_SEND      = 2'd3
    } icmp_state_e;

endpackage

// File: rtl/icmp_frame_assembler_word_buffer.sv
// Message word store: one synchronous write port, one combinational read port.
module icmp_word_buffer #(
    parameter int NUM_WORDS = 6,
    parameter int DATA_W    = 32,
    parameter int AW        = 3
) (
    input  logic              i_clock,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [NUM_WORDS];

    // Write port; contents need no reset since every word is rewritten before it is read.
    always_ff @(posedge i_clock) begin
        if (i_wr_en && (int'(i_wr_addr) < NUM_WORDS)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port; addresses past the last entry return zero.
    always_comb begin
        o_rd_data = '0;
        if (int'(i_rd_addr) < NUM_WORDS) begin
            o_rd_data = r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/icmp_frame_assembler.sv
// Buffers one ICMP message, patches the checksum into word 0 and streams it out.
module icmp_frame_assembler
    import icmp_pkg::*;
#(
    parameter int NUM_WORDS = ICMP_WORDS,
    parameter int DATA_W    = 32
) (
    input  logic              i_clock,
    input  logic              i_hardreset,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_csum_valid,
    input  logic [15:0]       i_csum_in,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_first,
    output logic              o_out_last,
    output logic              o_csum_late
);

    localparam int             CW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CW-1:0]  LAST = CW'(NUM_WORDS - 1);

    icmp_state_e       r_state;
    icmp_state_e       w_state_nxt;
    logic [CW-1:0]     r_wr_cnt;
    logic [CW-1:0]     r_rd_cnt;
    logic [15:0]       r_csum;
    logic              r_csum_held;
    logic              r_csum_late;
    logic              w_in_ready;
    logic              w_wr_en;
    logic              w_wr_last;
    logic              w_rd_last;
    logic              w_xfer;
    logic              w_csum_window;
    logic [DATA_W-1:0] w_rd_data;

    assign o_in_ready    = w_in_ready & ~i_hardreset;
    assign w_wr_en       = i_in_valid & o_in_ready;
    assign w_wr_last     = (r_wr_cnt == LAST);
    assign w_rd_last     = (r_rd_cnt == LAST);
    assign o_out_valid   = (r_state == ST_SEND);
    assign w_xfer        = o_out_valid & i_out_ready;
    assign w_csum_window = (r_state == ST_LOAD) || (r_state == ST_WAIT_CSUM);
    assign o_out_first   = o_out_valid && (r_rd_cnt == '0);
    assign o_out_last    = o_out_valid && w_rd_last;
    assign o_csum_late   = r_csum_late;

    icmp_word_buffer #(
        .NUM_WORDS (NUM_WORDS),
        .DATA_W    (DATA_W),
        .AW        (CW)
    ) u_buf (
        .i_clock   (i_clock),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_cnt),
        .i_wr_data (i_in_data),
        .i_rd_addr (r_rd_cnt),
        .o_rd_data (w_rd_data)
    );

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_hardreset) r_state <= ST_IDLE;
        else             r_state <= w_state_nxt;
    end

    // Next-state and input-ready decode.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (i_in_valid) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_in_ready = 1'b1;
                // A checksum on the same edge as the last word counts as already held.
                if (i_in_valid && w_wr_last) begin
                    w_state_nxt = (r_csum_held || i_csum_valid) ? ST_SEND : ST_WAIT_CSUM;
                end
            end
            ST_WAIT_CSUM: begin
                if (i_csum_valid) w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (w_xfer && w_rd_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Word counters and checksum capture / late-checksum flag.
    always_ff @(posedge i_clock) begin
        if (i_hardreset) begin
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_csum      <= '0;
            r_csum_held <= 1'b0;
            r_csum_late <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + 1'b1;
            if (i_csum_valid) begin
                if (w_csum_window) begin
                    r_csum      <= i_csum_in;
                    r_csum_held <= 1'b1;
                end else begin
                    r_csum_late <= 1'b1;
                end
            end
            if (w_xfer) begin
                if (w_rd_last) begin
                    r_rd_cnt    <= '0;
                    r_csum_held <= 1'b0;
                end else begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
            end
        end
    end

    // Output mux: word 0 carries the captured checksum in its low half.
    always_comb begin
        o_out_data = '0;
        if (o_out_valid) begin
            if (r_rd_cnt == '0) o_out_data = {w_rd_data[DATA_W-1:ICMP_CSUM_MSB+1], r_csum};
            else                o_out_data = w_rd_data;
        end
    end

endmodule

// File: tb/tb_icmp_frame_assembler.sv
// Self-checking bench for icmp_frame_assembler: scoreboard of expected output beats.
module tb_icmp_frame_assembler;

    typedef logic [31:0] msg_t [6];

    logic        clk = 1'b0;
    logic        hardreset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        csum_valid = 1'b0;
    logic [15:0] csum_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_first;
    logic        out_last;
    logic        csum_late;

    int checks = 0;
    int errors = 0;
    logic [33:0] sb [$];

    always #5 clk = ~clk;

    icmp_frame_assembler dut (
        .i_clock      (clk),
        .i_hardreset  (hardreset),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_data    (in_data),
        .i_csum_valid (csum_valid),
        .i_csum_in    (csum_in),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data),
        .o_out_first  (out_first),
        .o_out_last   (out_last),
        .o_csum_late  (csum_late)
    );

    // Scoreboard: every transferring beat is popped and compared.
    always @(negedge clk) begin
        if (!hardreset && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected data=%h first=%b last=%b required=none", out_data, out_first, out_last);
            end else begin
                logic [33:0] e;
                e = sb.pop_front();
                if ({out_data, out_first, out_last} !== e) begin
                    errors++;
                    $display("FAIL sb_beat data=%h first=%b last=%b required data=%h first=%b last=%b",
                             out_data, out_first, out_last, e[33:2], e[1], e[0]);
                end
            end
        end
    end

    function automatic void push_msg(input msg_t m, input logic [15:0] cs, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            logic [31:0] w;
            w = (k == 0) ? {m[0][31:16], cs} : m[k];
            sb.push_back({w, (k == 0), (k == 5)});
        end
    endfunction

    task automatic put_word(input logic [31:0] d, output int n);
        logic ok;
        n = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL put_word_timeout data=%h waited=%0d", d, n);
        end
    endtask

    task automatic feed_msg(input msg_t m, input int at_a, input logic [15:0] va,
                            input int at_b, input logic [15:0] vb, output int w0_wait);
        int n;
        w0_wait = 0;
        for (int k = 0; k < 6; k++) begin
            csum_valid = (k == at_a) || (k == at_b);
            csum_in    = (k == at_b) ? vb : va;
            put_word(m[k], n);
            if (k == 0) w0_wait = n;
            csum_valid = 1'b0;
        end
    endtask

    task automatic pulse_csum(input logic [15:0] v);
        csum_valid = 1'b1;
        csum_in    = v;
        @(posedge clk); #1;
        csum_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain left=%0d required=0", name, sb.size());
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_after out_valid=%b required=0", name, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        hardreset = 1'b1;
        in_valid  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_first, out_last, csum_late} !== 5'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs rdy=%b vld=%b first=%b last=%b late=%b data=%h required all 0",
                     in_ready, out_valid, out_first, out_last, csum_late, out_data);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        hardreset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready=%b required=1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_echo();
        msg_t m = '{32'h08000000, 32'h12340001, 32'hDEADBEEF, 32'h01020304, 32'hA5A5A5A5, 32'h00000000};
        int w;
        out_ready = 1'b1;
        push_msg(m, 16'h1B2C, 6);
        feed_msg(m, -1, 16'h0, -1, 16'h0, w);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL echo_wait in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        pulse_csum(16'h1B2C);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h08001B2C) begin
            errors++;
            $display("FAIL echo_latency out_valid=%b data=%h required 1 08001b2c", out_valid, out_data);
        end
        @(posedge clk); #1;
        wait_drain("echo");
    endtask

    task automatic test_early_csum();
        msg_t m = '{32'h0000FFFF, 32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888, 32'h9999AAAA};
        int w;
        out_ready = 1'b1;
        push_msg(m, 16'h7777, 6);
        feed_msg(m, 3, 16'h7777, -1, 16'h0, w);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_first !== 1'b1 || out_data[15:0] !== 16'h7777 || csum_late !== 1'b0) begin
            errors++;
            $display("FAIL early_send vld=%b first=%b csum=%h late=%b required 1 1 7777 0",
                     out_valid, out_first, out_data[15:0], csum_late);
        end
        @(posedge clk); #1;
        wait_drain("early");
    endtask

    task automatic test_backpressure();
        msg_t m = '{32'h0300ABCD, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 32'hCAFE0004, 32'hCAFE0005};
        int w;
        out_ready = 1'b0;
        push_msg(m, 16'h4242, 6);
        feed_msg(m, 5, 16'h4242, -1, 16'h0, w);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h03004242) begin
            errors++;
            $display("FAIL bp_same_edge_csum vld=%b data=%h required 1 03004242", out_valid, out_data);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'hCAFE0002 || out_first !== 1'b0 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d vld=%b data=%h first=%b last=%b required 1 cafe0002 0 0",
                         i, out_valid, out_data, out_first, out_last);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_drain("bp");
    endtask

    task automatic test_late_csum();
        msg_t m = '{32'h0B00DEAD, 32'h00000010, 32'h00000020, 32'h00000030, 32'h00000040, 32'h00000050};
        int w;
        out_ready = 1'b1;
        push_msg(m, 16'h2222, 6);
        feed_msg(m, 2, 16'h1111, 4, 16'h2222, w);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || csum_late !== 1'b0) begin
            errors++;
            $display("FAIL late_pre vld=%b late=%b required 1 0", out_valid, csum_late);
        end
        @(posedge clk); #1;
        pulse_csum(16'h3333);
        @(negedge clk);
        checks++;
        if (csum_late !== 1'b1) begin
            errors++;
            $display("FAIL late_flag late=%b required=1", csum_late);
        end
        @(posedge clk); #1;
        wait_drain("late");
        checks++;
        if (csum_late !== 1'b1) begin
            errors++;
            $display("FAIL late_sticky late=%b required=1", csum_late);
        end
    endtask

    task automatic test_reset_mid_send();
        msg_t m  = '{32'h08001234, 32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003, 32'hAAAA0004, 32'hAAAA0005};
        msg_t m2 = '{32'h00000000, 32'hBBBB0001, 32'hBBBB0002, 32'hBBBB0003, 32'hBBBB0004, 32'hBBBB0005};
        int w;
        out_ready = 1'b1;
        push_msg(m, 16'h5A5A, 3);
        feed_msg(m, 5, 16'h5A5A, -1, 16'h0, w);
        for (int n = 0; n < 50 && sb.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        hardreset = 1'b1;
        @(posedge clk); #1;
        hardreset = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if ({out_valid, out_first, out_last, csum_late} !== 4'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid vld=%b first=%b last=%b late=%b data=%h rdy=%b required 0 0 0 0 0 1",
                     out_valid, out_first, out_last, csum_late, out_data, in_ready);
        end
        @(posedge clk); #1;
        push_msg(m2, 16'hC0DE, 6);
        feed_msg(m2, -1, 16'h0, -1, 16'h0, w);
        pulse_csum(16'hC0DE);
        wait_drain("rst_fresh");
    endtask

    task automatic test_back_to_back();
        msg_t a = '{32'h08000000, 32'h10000001, 32'h10000002, 32'h10000003, 32'h10000004, 32'h10000005};
        msg_t b = '{32'h0000FFFF, 32'h20000001, 32'h20000002, 32'h20000003, 32'h20000004, 32'h20000005};
        int wa, wb;
        out_ready = 1'b1;
        push_msg(a, 16'hAAAA, 6);
        push_msg(b, 16'hBBBB, 6);
        feed_msg(a, 5, 16'hAAAA, -1, 16'h0, wa);
        feed_msg(b, 5, 16'hBBBB, -1, 16'h0, wb);
        checks++;
        if (wb != 7) begin
            errors++;
            $display("FAIL b2b_word0_wait cycles=%0d required=7", wb);
        end
        wait_drain("b2b");
    endtask

    initial begin
        test_reset();
        test_echo();
        test_early_csum();
        test_backpressure();
        test_late_csum();
        test_reset_mid_send();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
